credit_tx: RTL
==============

# credit_tx

Credit-based transmitter: the sending end of the valid/credit link used between stages of the functional-unit pipeline. Producers push words into a small internal FIFO; the block issues each word downstream as a one-cycle `valid_out` pulse only while it holds a credit. It consumes one credit per word sent and regains one credit per `credit_in` pulse returned by the downstream stage when that stage finishes processing. The block sits directly upstream of an FU stage and rate-matches the producer to it.

## Interface
- `BITS`, default `` `PATH_BITS ``: data word width.
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2. `AW = log2(DEPTH)`.
- `CREDITS`, default 1: initial and maximum credit count, equal to the downstream buffer slots (1 for a single FU stage).
- `CW`, default 4: credit counter width. `CREDITS ≤ 2^CW−1`.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high, on clock `clk`.
- `wr_en`  in  1  push `wr_data` this cycle.
- `wr_data`  in  BITS  word to push.
- `full`  out  1  FIFO holds DEPTH words. Registered.
- `empty`  out  1  FIFO holds 0 words. Registered.
- `valid_out`  out  1  one-cycle pulse: `data_out` carries a new word.
- `data_out`  out  BITS  word being sent. Holds its last value when `valid_out`=0.
- `credit_in`  in  1  one-cycle pulse: downstream freed one slot.
- `credits`  out  CW  current credit count.
- `err_overflow`  out  1  sticky: a write was dropped because the FIFO was full.
- `err_credit`  out  1  sticky: a credit arrived while `credits` was already at `CREDITS`.

## Operation
- State: FIFO array, `rd_ptr`/`wr_ptr` (AW bits, wrap modulo DEPTH), `count` (AW+1 bits), `credits`, output registers.
- Reset values: `valid_out`=0, `data_out`=0, `credits`=CREDITS, `count`=0, pointers=0, `empty`=1, `full`=0, both error flags 0.
- A reset applied mid-operation discards FIFO contents and any credits still in flight; `credits` returns to CREDITS.
- Write: `wr_acc = wr_en & !full`. Store at `wr_ptr`, then increment `wr_ptr`. If `wr_en & full`, drop the word and set `err_overflow`.
- Send: `send = !empty & (credits != 0)`, evaluated from registered state only.
  - On `send`: `valid_out`←1, `data_out`←`fifo[rd_ptr]`, `rd_ptr`++.
  - Otherwise: `valid_out`←0 and `data_out` holds.
- Count update: `count_next = count + wr_acc − send`. Simultaneous write and send leaves `count` unchanged. `full`/`empty` are registered from `count_next`.
- Credit update: `credits_next = credits − send + credit_in`.
  - Simultaneous send and credit leaves the count unchanged.
  - `credit_in` while `credits==CREDITS` and no send: `credits` saturates (unchanged) and `err_credit` sets.
  - Underflow cannot occur because `send` requires `credits != 0`.
- The FIFO preserves word order. No data is ever reordered or duplicated.
- Error flags clear only on reset.

## Timing
- Write-to-send latency: a word written at edge E0 (wr_en high in the cycle before E0) into an empty FIFO, with credit available, is sent at E1. `valid_out`=1 between E1 and E2. Minimum latency is one cycle.
- A credit arriving at edge E enables a send at edge E+1 at the earliest. `credits==0` blocks sending in the cycle the credit is sampled.
- Throughput: at most one word per cycle. Sustained rate is `min(1, CREDITS / round-trip cycles)`.
- `valid_out` never stays high for two consecutive cycles unless a send occurs in each of those cycles.
- `full` asserts the cycle after the DEPTH-th un-drained write. A write in that same cycle is dropped.

## Test plan
- Reset, then idle 5 cycles -> `valid_out`=0, `data_out`=0, `credits`=1, `empty`=1, `full`=0, both errors 0.
- CREDITS=1: write 0xA1, 0xA2 back-to-back; pulse `credit_in` 6 cycles after the first send -> 0xA1 is sent one cycle after its write, `credits`=0; 0xA2 is sent exactly one cycle after `credit_in`; `credits` ends at 0.
- DEPTH=4, no credits returned after the first send: write 6 words -> first word sent; words 2–5 fill the FIFO and `full`=1; word 6 is dropped and `err_overflow`=1. Then return 4 credits -> words 2–5 emerge in order and `empty`=1.
- CREDITS=2: write continuously while pulsing `credit_in` in the same cycle as each send -> `valid_out` pulses every cycle and `credits` stays constant.
- Pulse `credit_in` while `credits`=CREDITS and the FIFO is empty -> `credits` unchanged, `err_credit`=1 and stays 1.
- Assert `rst` with 3 words queued and `credits`=0 -> next cycle `count`=0, `credits`=CREDITS, `valid_out`=0; no stale word is ever sent afterwards.

Source files
------------

// File: rtl/credit_tx.sv
// credit_tx: credit-based link transmitter. Buffers producer words in a small
// FIFO and issues each one downstream as a single-cycle valid pulse, only
// while a downstream credit is held.
`ifndef PATH_BITS
`define PATH_BITS 32
`endif

module credit_tx #(
  parameter int unsigned BITS    = `PATH_BITS,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned CREDITS = 1,
  parameter int unsigned CW      = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [BITS-1:0] wr_data,
  output logic            full,
  output logic            empty,
  output logic            valid_out,
  output logic [BITS-1:0] data_out,
  input  logic            credit_in,
  output logic [CW-1:0]   credits,
  output logic            err_overflow,
  output logic            err_credit
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned CNTW = AW + 1;

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] count_next;
  logic [CW-1:0]   credits_next;
  logic            wr_acc;
  logic            send;
  logic            credit_sat;

  // Accept/send decisions and next occupancy/credit values from registered state
  always_comb begin
    wr_acc       = wr_en & ~full;
    send         = ~empty & (credits != '0);
    credit_sat   = credit_in & ~send & (credits == CW'(CREDITS));
    count_next   = count + CNTW'(wr_acc) - CNTW'(send);
    credits_next = credits;
    if (send && !credit_in) begin
      credits_next = credits - CW'(1);
    end else if (!send && credit_in && !credit_sat) begin
      credits_next = credits + CW'(1);
    end
  end

  // FIFO storage; contents need no reset since pointers/count gate every read
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy flags, credit counter, output and sticky error registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      credits      <= CW'(CREDITS);
      valid_out    <= 1'b0;
      data_out     <= '0;
      err_overflow <= 1'b0;
      err_credit   <= 1'b0;
    end else begin
      count   <= count_next;
      full    <= (count_next == CNTW'(DEPTH));
      empty   <= (count_next == '0);
      credits <= credits_next;
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      valid_out <= send;
      if (send) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + AW'(1);
      end
      if (wr_en && full) begin
        err_overflow <= 1'b1;
      end
      if (credit_sat) begin
        err_credit <= 1'b1;
      end
    end
  end

endmodule
